// File: rtl/mem_stream_reader_pkg.sv
// Shared types and constants for the memory stream reader.
package mem_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Entries in the output FIFO; also the cap on FIFO occupancy plus reads in flight.
  localparam int unsigned FIFO_DEPTH = 4;

  // Reads in flight: address-register stage plus RAM output stage.
  localparam int unsigned MAX_INFLIGHT = 2;

endpackage

// File: rtl/mem_stream_reader_if.sv
// RAM read port and output stream of the memory stream reader.
interface mem_stream_reader_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = 6
);

  logic [AW-1:0]    mem_address;
  logic             mem_wr_en;
  logic [WIDTH-1:0] mem_data;
  logic [WIDTH-1:0] mem_q;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output mem_address, mem_wr_en, mem_data, out_data, out_valid,
    input  mem_q, out_ready
  );

  modport slave (
    input  mem_address, mem_wr_en, mem_data, out_data, out_valid,
    output mem_q, out_ready
  );

endinterface

// File: rtl/mem_stream_reader_fifo.sv
// Small synchronous FIFO buffering RAM read data ahead of the output stream.
module stream_fifo
  import mem_stream_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = FIFO_DEPTH,
  localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] store_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Qualify push/pop against occupancy and compute next pointers/count.
  always_comb begin
    do_pop   = pop_i && (count_q != '0);
    do_push  = push_i && ((count_q != CW'(DEPTH)) || do_pop);
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk_i) begin
    if (do_push) store_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = store_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/mem_stream_reader.sv
// Reads a block of words from a single-port RAM and streams them out in address order.
module mem_stream_reader
  import mem_stream_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 64,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   length,
  output logic          busy,
  output logic          done,
  mem_stream_reader_if.master bus
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  state_e                  state_q, state_d;
  logic [AW-1:0]           addr_q, addr_d;
  logic [AW-1:0]           mem_addr_q, mem_addr_d;
  logic [AW:0]             remain_q, remain_d;
  logic [MAX_INFLIGHT-1:0] pipe_q;
  logic                    done_q, done_d;
  logic                    issue;
  logic [AW:0]             len_eff;
  logic [3:0]              occupancy;
  logic                    room;
  logic [CW-1:0]           fifo_count;
  logic                    fifo_empty;
  logic                    pop;

  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
    return (a == AW'(DEPTH - 1)) ? '0 : a + 1'b1;
  endfunction

  assign len_eff   = (length > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : length;
  assign occupancy = 4'(fifo_count) + 4'($countones(pipe_q));
  assign room      = occupancy < 4'(FIFO_DEPTH);
  assign pop       = !fifo_empty && bus.out_ready;

  // Next-state logic; the accepted start itself issues the first read so the
  // first beat lands two cycles after the start edge.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    mem_addr_d = mem_addr_q;
    remain_d   = remain_q;
    done_d     = 1'b0;
    issue      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (len_eff == '0) begin
            done_d = 1'b1;
          end else begin
            issue      = 1'b1;
            mem_addr_d = base_addr;
            addr_d     = next_addr(base_addr);
            remain_d   = len_eff - 1'b1;
            state_d    = READ;
          end
        end
      end
      READ: begin
        if (remain_q == '0) begin
          state_d = DRAIN;
        end else if (room) begin
          issue      = 1'b1;
          mem_addr_d = addr_q;
          addr_d     = next_addr(addr_q);
          remain_d   = remain_q - 1'b1;
          if (remain_q == (AW+1)'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && (fifo_count == CW'(1)) && (pipe_q == '0)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and address registers.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      mem_addr_q <= '0;
      remain_q   <= '0;
      pipe_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      mem_addr_q <= mem_addr_d;
      remain_q   <= remain_d;
      pipe_q     <= {pipe_q[MAX_INFLIGHT-2:0], issue};
      done_q     <= done_d;
    end
  end

  stream_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clock),
    .rst_ni  (rst_n),
    .push_i  (pipe_q[MAX_INFLIGHT-1]),
    .data_i  (bus.mem_q),
    .pop_i   (pop),
    .data_o  (bus.out_data),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign bus.mem_address = mem_addr_q;
  assign bus.mem_wr_en   = 1'b0;
  assign bus.mem_data    = '0;
  assign bus.out_valid   = !fifo_empty;
  assign busy            = (state_q != IDLE);
  assign done            = done_q;

endmodule

// File: tb/tb_mem_stream_reader.sv
// Directed and randomized checks of mem_stream_reader against a queue-based model.
module tb_mem_stream_reader;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned AW    = 6;

  logic          clock = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic          busy;
  logic          done;

  logic [WIDTH-1:0] ram [DEPTH];

  int checks  = 0;
  int errors  = 0;
  int max_occ = 0;

  mem_stream_reader_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

  mem_stream_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .bus       (bus)
  );

  initial forever #5 clock = ~clock;

  // Synchronous-read RAM: data appears the cycle after the address edge.
  always @(posedge clock) bus.mem_q <= ram[bus.mem_address];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic ready_for(input int unsigned mode, input int unsigned c);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (c % 2 == 0);
    return 1'($urandom_range(0, 1));
  endfunction

  // One transfer: expected beats are ram[(base+k) mod DEPTH] for k < min(len, DEPTH).
  task automatic run_xfer(input int unsigned base, input int unsigned len,
                          input int unsigned mode, input int inject_at, input bit chain);
    logic [WIDTH-1:0] exp_q [$];
    int unsigned      n, cyc, beats;
    int               first_cyc, last_cyc;
    bit               seen_done, stalled;
    logic [WIDTH-1:0] held;
    n = (len > DEPTH) ? DEPTH : len;
    for (int unsigned k = 0; k < n; k++) exp_q.push_back(ram[(base + k) % DEPTH]);
    first_cyc = -1; last_cyc = -1; seen_done = 0; stalled = 0; held = '0;
    beats = 0; max_occ = 0;
    start = 1'b1; base_addr = AW'(base); length = (AW+1)'(len); bus.out_ready = 1'b1;
    step();
    start = 1'b0;
    cyc = 0;
    while (!seen_done && cyc < 400) begin
      if (cyc == 0) begin
        check("busy_after_start", 32'(busy), 1);
        check("no_done_at_start", 32'(done), 0);
      end
      if (cyc == 1) check("valid_before_latency", 32'(bus.out_valid), 0);
      if (cyc == 2) check("valid_at_latency", 32'(bus.out_valid), 1);
      if (stalled) begin
        check("stall_valid", 32'(bus.out_valid), 1);
        check("stall_data", 32'(bus.out_data), 32'(held));
      end
      if (int'(dut.fifo_count) > max_occ) max_occ = int'(dut.fifo_count);
      if (done === 1'b1) begin
        seen_done = 1;
        check("done_after_last", 32'(cyc), 32'(last_cyc + 1));
      end else begin
        bus.out_ready = ready_for(mode, cyc);
        if (inject_at == int'(cyc)) begin
          start = 1'b1; base_addr = AW'(40); length = (AW+1)'(3);
        end else begin
          start = 1'b0;
        end
        if (bus.out_valid && bus.out_ready) begin
          check("beat_within_len", 32'(beats < n), 1);
          if (beats < n) check("beat_data", 32'(bus.out_data), 32'(exp_q[beats]));
          if (first_cyc < 0) first_cyc = int'(cyc);
          last_cyc = int'(cyc);
          beats++;
        end
        stalled = bus.out_valid && !bus.out_ready;
        held    = bus.out_data;
        step();
        cyc++;
      end
    end
    start = 1'b0;
    check("xfer_completes", 32'(seen_done), 1);
    check("beat_total", 32'(beats), 32'(n));
    if (mode == 0) begin
      check("first_beat_cycle", 32'(first_cyc), 2);
      check("back_to_back", 32'(last_cyc - first_cyc), 32'(n - 1));
    end
    if (!chain) begin
      step();
      check("done_one_cycle", 32'(done), 0);
      check("idle_after", 32'(busy), 0);
      check("valid_idle", 32'(bus.out_valid), 0);
    end
  endtask

  initial begin
    int unsigned beats, cyc;
    rst_n = 1'b0; start = 1'b0; base_addr = '0; length = '0; bus.out_ready = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) ram[i] = WIDTH'(i);
    #3;
    check("rst_valid", 32'(bus.out_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_addr", 32'(bus.mem_address), 0);
    check("rst_wr_en", 32'(bus.mem_wr_en), 0);
    check("rst_wdata", 32'(bus.mem_data), 0);
    step(); step();
    rst_n = 1'b1;

    // Basic transfer, then a wrap across the top of memory chained directly off done.
    run_xfer(5, 4, 0, -1, 1);
    run_xfer(62, 4, 0, -1, 0);

    // Zero length: done next cycle only, nothing else happens.
    start = 1'b1; base_addr = AW'(7); length = '0;
    step();
    start = 1'b0;
    check("len0_done", 32'(done), 1);
    check("len0_busy", 32'(busy), 0);
    check("len0_valid", 32'(bus.out_valid), 0);
    step();
    check("len0_done_once", 32'(done), 0);
    for (int i = 0; i < 3; i++) begin
      check("len0_quiet", 32'({bus.out_valid, busy, done}), 0);
      step();
    end

    // Toggling ready with occupancy bound.
    run_xfer(0, 8, 1, -1, 0);
    check("occ_le4", 32'(max_occ <= 4), 1);

    // Start while busy is ignored.
    run_xfer(10, 6, 0, 3, 0);

    // Full-depth transfer wrapping the address space.
    run_xfer(60, 64, 0, -1, 0);

    // Reset in the middle of a transfer.
    start = 1'b1; base_addr = AW'(20); length = (AW+1)'(10); bus.out_ready = 1'b1;
    step();
    start = 1'b0;
    beats = 0; cyc = 0;
    while (beats < 2 && cyc < 20) begin
      if (bus.out_valid && bus.out_ready) begin
        check("rst_pre_beat", 32'(bus.out_data), 32'(20 + beats));
        beats++;
      end
      step();
      cyc++;
    end
    check("rst_two_beats", 32'(beats), 2);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bus.out_valid), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_done", 32'(done), 0);
    check("mid_rst_addr", 32'(bus.mem_address), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("mid_rst_no_done", 32'(done), 0);
    end
    rst_n = 1'b1;
    run_xfer(0, 2, 0, -1, 0);

    // Randomized contents, addresses, lengths and backpressure.
    for (int t = 0; t < 6; t++) begin
      for (int unsigned i = 0; i < DEPTH; i++) ram[i] = WIDTH'($urandom);
      run_xfer($urandom_range(0, DEPTH - 1), $urandom_range(1, 24), 2, -1, (t % 2 == 0));
      check("rand_occ_le4", 32'(max_occ <= 4), 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
